// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops into a head+skid buffer and presents a
// first-word-fall-through valid/ready stream with a wrapping transfer counter.
module fifo_rd_stream #(
  parameter int unsigned D_SIZE = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              rclk,
  input  logic              rrstn,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  input  logic [D_SIZE-1:0] fifo_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [D_SIZE-1:0] m_data,
  output logic [1:0]        level,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam logic [1:0] LVL_EMPTY = 2'd0;
  localparam logic [1:0] LVL_ONE   = 2'd1;
  localparam logic [1:0] LVL_FULL  = 2'd2;

  logic [1:0]        level_q, level_d;
  logic [D_SIZE-1:0] head_q, head_d;
  logic [D_SIZE-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pop;
  logic              xfer;

  // Pop decision uses only local state, so m_ready never reaches fifo_ren.
  always_comb begin
    fifo_ren = rrstn & ~fifo_empty & (level_q != LVL_FULL) & ~flush;
    m_valid  = (level_q != LVL_EMPTY) & ~flush;
    pop      = fifo_ren;
    xfer     = m_valid & m_ready;

    level_d  = level_q;
    head_d   = head_q;
    skid_d   = skid_q;
    cnt_d    = xfer ? cnt_q + CNT_W'(1) : cnt_q;

    if (flush) begin
      level_d = LVL_EMPTY;
    end else begin
      unique case (level_q)
        LVL_EMPTY: begin
          if (pop) begin
            head_d  = fifo_rdata;
            level_d = LVL_ONE;
          end
        end
        LVL_ONE: begin
          if (pop && xfer) begin
            head_d = fifo_rdata;
          end else if (pop) begin
            skid_d  = fifo_rdata;
            level_d = LVL_FULL;
          end else if (xfer) begin
            level_d = LVL_EMPTY;
          end
        end
        LVL_FULL: begin
          if (xfer) begin
            head_d  = skid_q;
            level_d = LVL_ONE;
          end
        end
        default: level_d = LVL_EMPTY;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      level_q <= LVL_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_data   = head_q;
  assign level    = level_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO source, vector table,
// and stream sequences for throttling, reset and counter wrap.
module tb_fifo_rd_stream;

  logic        rclk = 1'b0;
  logic        rrstn;
  logic        flush;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        m_ready;

  logic        ren, valid;
  logic [7:0]  data;
  logic [1:0]  lvl;
  logic [15:0] cnt;

  logic        ren4, valid4;
  logic [7:0]  data4;
  logic [1:0]  lvl4;
  logic [3:0]  cnt4;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] fq[$];
  logic [7:0] sb[$];

  typedef struct {
    bit         push;
    logic [7:0] wd;
    bit         rdy;
    bit         fl;
    bit         e_ren;
    bit         e_vld;
    logic [1:0] e_lvl;
    logic [7:0] e_data;
    int         e_cnt;
  } vec_t;

  vec_t vt[27];

  always #5 rclk = ~rclk;

  fifo_rd_stream dut (
    .rclk(rclk), .rrstn(rrstn), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_ren(ren), .fifo_rdata(fifo_rdata), .m_valid(valid), .m_ready(m_ready),
    .m_data(data), .level(lvl), .xfer_cnt(cnt)
  );

  fifo_rd_stream #(.D_SIZE(8), .CNT_W(4)) dut4 (
    .rclk(rclk), .rrstn(rrstn), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_ren(ren4), .fifo_rdata(fifo_rdata), .m_valid(valid4), .m_ready(m_ready),
    .m_data(data4), .level(lvl4), .xfer_cnt(cnt4)
  );

  function automatic vec_t mk(bit push, logic [7:0] wd, bit rdy, bit fl,
                              bit e_ren, bit e_vld, logic [1:0] e_lvl,
                              logic [7:0] e_data, int e_cnt);
    vec_t v;
    v.push = push; v.wd = wd; v.rdy = rdy; v.fl = fl;
    v.e_ren = e_ren; v.e_vld = e_vld; v.e_lvl = e_lvl;
    v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = fifo_empty ? 8'h00 : fq[0];
  endtask

  // One clock: the behavioural FIFO pops if the DUT asserted ren before the edge.
  task automatic tick();
    logic r;
    r = ren;
    @(posedge rclk);
    #1;
    if (r && fq.size() != 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic run_stream(input int n, input bit toggle);
    int got;
    int cyc;
    logic [7:0] exp;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 400) begin
      m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      chk("ren_while_empty", 32'(ren & fifo_empty), 32'd0);
      if (valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("extra_word", 32'(data), 32'hFFFF_FFFF);
        end else begin
          exp = sb.pop_front();
          chk($sformatf("stream_word%0d", got), 32'(data), 32'(exp));
        end
        got++;
      end
      tick();
      cyc++;
    end
    chk("stream_count", 32'(got), 32'(n));
  endtask

  initial begin
    vt[0]  = mk(1, 8'h11, 1, 0, 1, 0, 2'd0, 8'h00, 0);
    vt[1]  = mk(1, 8'h22, 1, 0, 1, 1, 2'd1, 8'h11, 0);
    vt[2]  = mk(1, 8'h33, 1, 0, 1, 1, 2'd1, 8'h22, 1);
    vt[3]  = mk(0, 8'h00, 1, 0, 0, 1, 2'd1, 8'h33, 2);
    vt[4]  = mk(0, 8'h00, 1, 0, 0, 0, 2'd0, 8'h00, 3);
    vt[5]  = mk(1, 8'hA1, 0, 0, 1, 0, 2'd0, 8'h00, 3);
    vt[6]  = mk(1, 8'hA2, 0, 0, 1, 1, 2'd1, 8'hA1, 3);
    vt[7]  = mk(1, 8'hA3, 0, 0, 0, 1, 2'd2, 8'hA1, 3);
    vt[8]  = mk(1, 8'hA4, 0, 0, 0, 1, 2'd2, 8'hA1, 3);
    vt[9]  = mk(0, 8'h00, 0, 0, 0, 1, 2'd2, 8'hA1, 3);
    vt[10] = mk(0, 8'h00, 1, 0, 0, 1, 2'd2, 8'hA1, 3);
    vt[11] = mk(0, 8'h00, 1, 0, 1, 1, 2'd1, 8'hA2, 4);
    vt[12] = mk(0, 8'h00, 1, 0, 1, 1, 2'd1, 8'hA3, 5);
    vt[13] = mk(0, 8'h00, 1, 0, 0, 1, 2'd1, 8'hA4, 6);
    vt[14] = mk(0, 8'h00, 1, 0, 0, 0, 2'd0, 8'h00, 7);
    vt[15] = mk(1, 8'hA5, 0, 0, 1, 0, 2'd0, 8'h00, 7);
    vt[16] = mk(1, 8'h5A, 0, 0, 1, 1, 2'd1, 8'hA5, 7);
    vt[17] = mk(1, 8'hC3, 0, 0, 0, 1, 2'd2, 8'hA5, 7);
    vt[18] = mk(0, 8'h00, 1, 1, 0, 0, 2'd2, 8'h00, 7);
    vt[19] = mk(0, 8'h00, 1, 0, 1, 0, 2'd0, 8'h00, 7);
    vt[20] = mk(0, 8'h00, 1, 0, 0, 1, 2'd1, 8'hC3, 7);
    vt[21] = mk(0, 8'h00, 1, 0, 0, 0, 2'd0, 8'h00, 8);
    vt[22] = mk(1, 8'hD1, 0, 1, 0, 0, 2'd0, 8'h00, 8);
    vt[23] = mk(0, 8'h00, 0, 1, 0, 0, 2'd0, 8'h00, 8);
    vt[24] = mk(0, 8'h00, 0, 0, 1, 0, 2'd0, 8'h00, 8);
    vt[25] = mk(0, 8'h00, 1, 0, 0, 1, 2'd1, 8'hD1, 8);
    vt[26] = mk(0, 8'h00, 1, 0, 0, 0, 2'd0, 8'h00, 9);

    rrstn = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_rdata = 8'h00;
    #12;
    chk("rst_ren", 32'(ren), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_level", 32'(lvl), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    fq.push_back(8'h77);
    drive_fifo();
    #1;
    chk("rst_ren_nonempty", 32'(ren), 32'd0);
    fq.delete();
    drive_fifo();
    @(posedge rclk);
    #1 rrstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("idle%0d_ren", i), 32'(ren), 32'd0);
      chk($sformatf("idle%0d_valid", i), 32'(valid), 32'd0);
      chk($sformatf("idle%0d_level", i), 32'(lvl), 32'd0);
      chk($sformatf("idle%0d_cnt", i), 32'(cnt), 32'd0);
      tick();
    end

    for (int i = 0; i < 27; i++) begin
      if (vt[i].push) fq.push_back(vt[i].wd);
      m_ready = vt[i].rdy;
      flush   = vt[i].fl;
      drive_fifo();
      #1;
      chk($sformatf("row%0d_ren", i), 32'(ren), 32'(vt[i].e_ren));
      chk($sformatf("row%0d_valid", i), 32'(valid), 32'(vt[i].e_vld));
      chk($sformatf("row%0d_level", i), 32'(lvl), 32'(vt[i].e_lvl));
      chk($sformatf("row%0d_cnt", i), 32'(cnt), 32'(vt[i].e_cnt));
      chk($sformatf("row%0d_ren4", i), 32'(ren4), 32'(vt[i].e_ren));
      chk($sformatf("row%0d_valid4", i), 32'(valid4), 32'(vt[i].e_vld));
      chk($sformatf("row%0d_level4", i), 32'(lvl4), 32'(vt[i].e_lvl));
      chk($sformatf("row%0d_cnt4", i), 32'(cnt4), 32'(vt[i].e_cnt % 16));
      if (vt[i].e_vld) begin
        chk($sformatf("row%0d_data", i), 32'(data), 32'(vt[i].e_data));
        chk($sformatf("row%0d_data4", i), 32'(data4), 32'(vt[i].e_data));
      end
      tick();
    end
    flush = 1'b0;

    // Throttled sink against a continuously supplied FIFO.
    m_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      fq.push_back(8'(i));
      sb.push_back(8'(i));
    end
    drive_fifo();
    run_stream(32, 1'b1);
    #1;
    chk("toggle_level_end", 32'(lvl), 32'd0);
    chk("toggle_cnt_end", 32'(cnt), 32'd41);

    // Asynchronous reset in the middle of a running stream.
    for (int i = 0; i < 4; i++) fq.push_back(8'h40 + 8'(i));
    m_ready = 1'b1;
    drive_fifo();
    tick();
    tick();
    #3 rrstn = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_ren", 32'(ren), 32'd0);
    chk("arst_level", 32'(lvl), 32'd0);
    chk("arst_cnt", 32'(cnt), 32'd0);
    chk("arst_cnt4", 32'(cnt4), 32'd0);
    chk("arst_data", 32'(data), 32'd0);
    fq.delete();
    sb.delete();
    drive_fifo();
    @(posedge rclk);
    #1 rrstn = 1'b1;

    // 17 transfers wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      fq.push_back(8'h80 + 8'(i));
      sb.push_back(8'h80 + 8'(i));
    end
    drive_fifo();
    run_stream(17, 1'b0);
    #1;
    chk("wrap_cnt16", 32'(cnt), 32'd17);
    chk("wrap_cnt4", 32'(cnt4), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
